// File: rtl/pes_elevator_req_sched_if.sv
// pes_elevator_req_sched_if: call, position and dispatch signals between the scheduler and pes_elevator.
interface pes_elevator_req_sched_if #(parameter int N_FLOORS = 8);
  logic [N_FLOORS-1:0] call_btn, current_floor, request_floor, pending;
  logic complete, req_valid, sweep_up, busy;
  modport master(
    output call_btn, current_floor, complete,
    input  request_floor, req_valid, pending, sweep_up, busy
  );
  modport slave(
    input  call_btn, current_floor, complete,
    output request_floor, req_valid, pending, sweep_up, busy
  );
endinterface

// File: rtl/pes_elevator_req_sched.sv
// pes_elevator_req_sched: latches floor calls and dispatches one-hot targets to pes_elevator using SCAN.
// Optional idle parking to floor 0 is enabled by defining PES_REQ_SCHED_PARK_EN.
module pes_elevator_req_sched #(
  parameter int N_FLOORS    = 8,
  parameter int PARK_CYCLES = 64
) (
  input logic                     clk_i,
  input logic                     rst_ni,
  pes_elevator_req_sched_if.slave bus_io
);
  typedef enum logic [1:0] {IDLE, SELECT, DISPATCH, RETIRE} state_e;
  state_e state_q, state_d;
  logic [N_FLOORS-1:0] target_q, target_d, pending_q, pending_d, retire, sel_tgt;
  logic sweep_q, sweep_d, has_up, has_dn, sel_up, sel_dn, park_q, park_go;
  int cur, up_idx, dn_idx;

  if (PARK_CYCLES < 2) begin : g_park_chk
    $error("PARK_CYCLES must be at least 2");
  end

  // Nearest pending floor above and below the car; the sweep direction picks between them.
  always_comb begin
    cur    = 0;
    up_idx = 0;
    dn_idx = 0;
    has_up = 1'b0;
    has_dn = 1'b0;
    for (int i = 0; i < N_FLOORS; i++) if (bus_io.current_floor[i]) cur = i;
    for (int i = N_FLOORS - 1; i >= 0; i--) if (pending_q[i] && i > cur) begin
      has_up = 1'b1;
      up_idx = i;
    end
    for (int i = 0; i < N_FLOORS; i++) if (pending_q[i] && i < cur) begin
      has_dn = 1'b1;
      dn_idx = i;
    end
    sel_up  = has_up && (sweep_q || !has_dn);
    sel_dn  = has_dn && !sel_up;
    sel_tgt = sel_up ? N_FLOORS'(1) << up_idx : sel_dn ? N_FLOORS'(1) << dn_idx : bus_io.current_floor;
  end

  assign retire    = (state_q == RETIRE && !park_q) ? target_q : '0;
  assign pending_d = (pending_q | bus_io.call_btn) & ~retire;

`ifdef PES_REQ_SCHED_PARK_EN
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic park_d;
  assign park_go    = state_q == IDLE && pending_d == '0 && idle_cnt_q >= 16'(PARK_CYCLES) && !bus_io.current_floor[0];
  assign idle_cnt_d = (state_q == IDLE && pending_d == '0 && !park_go) ? idle_cnt_q + 16'(idle_cnt_q < 16'(PARK_CYCLES)) : '0;
  assign park_d     = park_go || (park_q && state_q != RETIRE);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      idle_cnt_q <= '0;
      park_q     <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      park_q     <= park_d;
    end
`else
  assign park_go = 1'b0;
  assign park_q  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    target_d = park_go ? N_FLOORS'(1) : target_q;
    sweep_d  = sweep_q;
    unique case (state_q)
      IDLE:     state_d = pending_d != '0 ? SELECT : park_go ? DISPATCH : IDLE;
      SELECT:   if ($onehot(bus_io.current_floor)) begin
        state_d  = DISPATCH;
        target_d = sel_tgt;
        sweep_d  = sel_up ? 1'b1 : sel_dn ? 1'b0 : sweep_q;
      end
      DISPATCH: if (bus_io.complete && bus_io.current_floor == target_q) state_d = RETIRE;
      default:  state_d = pending_d != '0 ? SELECT : IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q   <= IDLE;
      target_q  <= '0;
      pending_q <= '0;
      sweep_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      pending_q <= pending_d;
      sweep_q   <= sweep_d;
    end

  assign bus_io.request_floor = state_q == DISPATCH ? target_q : '0;
  assign bus_io.req_valid     = state_q == DISPATCH;
  assign bus_io.pending       = pending_q;
  assign bus_io.sweep_up      = sweep_q;
  assign bus_io.busy          = state_q != IDLE;
endmodule
